// File: rtl/prbs_multi_generator_if.sv
// Control/data bundle for one PRBS lane.
//   master: drives enable, user_freq, mode, seed, seed_load, inject_err;
//           observes signal_out, signal_valid, signal_cycle.
//   slave : the generator side of the same signals.
interface prbs_multi_generator_if #(
  parameter int FREQ_W = 32
);
  logic              enable;
  logic [FREQ_W-1:0] user_freq;
  logic [2:0]        mode;
  logic [30:0]       seed;
  logic              seed_load;
  logic              inject_err;
  logic              signal_out;
  logic              signal_valid;
  logic              signal_cycle;

  modport master (
    output enable, user_freq, mode, seed, seed_load, inject_err,
    input  signal_out, signal_valid, signal_cycle
  );
  modport slave (
    input  enable, user_freq, mode, seed, seed_load, inject_err,
    output signal_out, signal_valid, signal_cycle
  );
endinterface

// File: rtl/prbs_multi_generator.sv
// Fibonacci LFSR PRBS source with run-time polynomial select (PRBS7/9/15/23/31),
// loadable seed, clock-enable divider, one-shot error injection and valid/period strobes.
// Ports:
//   clk   system clock
//   reset asynchronous, active-high
//   bus   prbs_multi_generator_if.slave (controls in, signal_out/valid/cycle out)
module prbs_multi_generator #(
  parameter int          FREQ_W       = 32,
  parameter logic [2:0]  DEFAULT_MODE = 3'd4,
  parameter logic [30:0] DEFAULT_SEED = 31'h7FFFFFFF
) (
  input logic                   clk,
  input logic                   reset,
  prbs_multi_generator_if.slave bus
);

  // Active-width mask of the LFSR for a decoded mode.
  function automatic logic [30:0] f_mask(input logic [2:0] m);
    case (m)
      3'd0:    f_mask = 31'h0000007F;
      3'd1:    f_mask = 31'h000001FF;
      3'd2:    f_mask = 31'h00007FFF;
      3'd3:    f_mask = 31'h007FFFFF;
      default: f_mask = 31'h7FFFFFFF;
    endcase
  endfunction

  // Modes 5-7 alias PRBS31.
  function automatic logic [2:0] f_dec(input logic [2:0] m);
    f_dec = (m > 3'd4) ? 3'd4 : m;
  endfunction

  // Seed masked to the active width; all-zero would lock the LFSR, so use all-ones.
  function automatic logic [30:0] f_load(input logic [30:0] s, input logic [2:0] m);
    logic [30:0] v;
    v      = s & f_mask(m);
    f_load = (v == 31'd0) ? f_mask(m) : v;
  endfunction

  localparam logic [2:0]  RST_MODE = f_dec(DEFAULT_MODE);
  localparam logic [30:0] RST_LFSR = f_load(DEFAULT_SEED, RST_MODE);

  logic [2:0]        r_mode;
  logic [30:0]       r_lfsr;
  logic [30:0]       r_per;
  logic [FREQ_W-1:0] r_div;
  logic              r_err;
  logic              r_out;
  logic              r_vld;
  logic              r_cyc;

  logic [2:0]  w_mode;
  logic        w_fb;
  logic [30:0] w_shift;
  logic        w_term;
  logic        w_per_last;
  logic        w_inj;

  assign w_mode = f_dec(bus.mode);
  assign w_inj  = r_err | bus.inject_err;

  always_comb begin
    w_fb = 1'b0;
    case (r_mode)
      3'd0:    w_fb = r_lfsr[6]  ^ r_lfsr[5];
      3'd1:    w_fb = r_lfsr[8]  ^ r_lfsr[4];
      3'd2:    w_fb = r_lfsr[14] ^ r_lfsr[13];
      3'd3:    w_fb = r_lfsr[22] ^ r_lfsr[17];
      default: w_fb = r_lfsr[30] ^ r_lfsr[27];
    endcase
  end

  // Masking keeps bits above the active width at zero.
  assign w_shift    = {r_lfsr[29:0], w_fb} & f_mask(r_mode);
  // Period of an N-bit maximal LFSR is 2^N-1 steps, so the last step sees 2^N-2.
  assign w_per_last = (r_per == (f_mask(r_mode) - 31'd1));
  // >= rather than == so a user_freq lowered below the running count wraps at once.
  assign w_term     = (bus.user_freq <= FREQ_W'(1)) ||
                      (r_div >= (bus.user_freq - FREQ_W'(1)));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_mode <= RST_MODE;
      r_lfsr <= RST_LFSR;
      r_per  <= '0;
      r_div  <= '0;
      r_err  <= 1'b0;
      r_out  <= 1'b0;
      r_vld  <= 1'b0;
      r_cyc  <= 1'b0;
    end else begin
      r_vld <= 1'b0;
      r_cyc <= 1'b0;
      if (bus.seed_load) begin
        r_lfsr <= f_load(bus.seed, r_mode);
        r_div  <= '0;
        r_per  <= '0;
        r_err  <= w_inj;
      end else if (w_mode != r_mode) begin
        r_mode <= w_mode;
        r_lfsr <= f_load(bus.seed, w_mode);
        r_div  <= '0;
        r_per  <= '0;
        r_err  <= w_inj;
      end else if (bus.enable && w_term) begin
        r_div  <= '0;
        r_lfsr <= w_shift;
        r_out  <= w_fb ^ w_inj;     // an injection landing on a step flips that bit
        r_err  <= 1'b0;
        r_vld  <= 1'b1;
        if (w_per_last) begin
          r_per <= '0;
          r_cyc <= 1'b1;
        end else begin
          r_per <= r_per + 31'd1;
        end
      end else begin
        if (bus.enable) r_div <= r_div + FREQ_W'(1);
        r_err <= w_inj;             // held until the next step, even while disabled
      end
    end
  end

  assign bus.signal_out   = r_out;
  assign bus.signal_valid = r_vld;
  assign bus.signal_cycle = r_cyc;

endmodule
